regfile_bubble_sorter: RTL and testbench
========================================

// Module: regfile_bubble_sorter
// PURPOSE
//  Sorting engine that sits beside the 16x8 register file and drives its read and write ports.
//  On Start it bubble-sorts the register file contents in place, ascending or descending, using
//  the single combinational read port and the single synchronous write port. It reports Busy,
//  a one-cycle Done pulse and the number of swaps performed. Pass shrinks by one each time;
//  the sort terminates early after any pass with no swaps.
// PARAMETERS
//  DEPTH    16  number of register-file entries to sort (>=2)
//  WIDTH    8   data width of each entry (unsigned)
//  ADDR_W   4   register-file address width (2**ADDR_W >= DEPTH)
//  COUNT_W  8   SwapCount width; the count saturates at all-ones
// PORTS
//  Clk        in   1        clock, all state changes on rising edge
//  Rst        in   1        synchronous, active-high reset
//  Start      in   1        request a sort; sampled only in IDLE
//  Desc       in   1        0 = ascending, 1 = descending; captured when Start is accepted
//  R_Data     in   WIDTH    register-file read data (combinational, same cycle as R_Addr)
//  R_Addr     out  ADDR_W   register-file read address
//  R_en       out  1        register-file read enable
//  W_Addr     out  ADDR_W   register-file write address
//  W_en       out  1        register-file write enable
//  W_Data     out  WIDTH    register-file write data
//  Busy       out  1        high in every state except IDLE
//  Done       out  1        one-cycle pulse in the DONE state
//  SwapCount  out  COUNT_W  swaps performed by the last/current sort
// BEHAVIOUR
//  - Reset: state=IDLE. Busy=0, Done=0, R_en=0, W_en=0, R_Addr=0, W_Addr=0, W_Data=0, SwapCount=0.
//    The index, limit, swapped and order registers are cleared.
//  - Outputs are decoded from the state and index registers. R_en=1 only in RD_A/RD_B.
//    W_en=1 only in WR_A/WR_B.
//  - IDLE: on Start=1, do all of the following, then go to RD_A:
//    latch Desc; i=0; limit=DEPTH-2; swapped=0; SwapCount=0.
//  - RD_A: R_Addr=i; capture a<=R_Data at the edge; go to RD_B.
//  - RD_B: R_Addr=i+1; capture b<=R_Data at the edge; go to CMP.
//  - CMP: out_of_order = Desc ? (a<b) : (a>b), unsigned compare; equal values are never swapped.
//    If out_of_order: go to WR_A.
//    Otherwise go to RD_A or DONE, per the end-of-compare rule below.
//  - WR_A: W_Addr=i, W_Data=b; go to WR_B.
//  - WR_B: W_Addr=i+1, W_Data=a; set swapped=1; SwapCount+=1 (saturating).
//    Then apply the end-of-compare rule.
//  - End-of-compare rule:
//    if i<limit: i+=1 and go to RD_A;
//    else if swapped=0 or limit=0: go to DONE;
//    else: limit-=1, i=0, swapped=0, go to RD_A.
//  - DONE: Done=1 for exactly one cycle, Busy=1; then go to IDLE.
//  - Latency: 3 cycles per compare without a swap, 5 with a swap, +1 DONE cycle.
//    Start sampled at edge E0; RD_A occupies cycle 1.
//  - Start while Busy is ignored and is not queued. Start and Rst together: Rst wins.
//  - SwapCount holds its value in IDLE until the next accepted Start.
//  - Rst mid-sort aborts the sort immediately, with no further writes.
//    All outputs take their reset values the cycle after the edge.
//  - Only addresses 0..DEPTH-1 are ever driven.
// TESTING
//  1. Rst, then Start with Desc=0 on the reset contents
//     {47,56,51,48,53,55,52,39,54,49,57,50,46,53,63,57}
//     -> final contents {39,46,47,48,49,50,51,52,53,53,54,55,56,57,57,63}; SwapCount=46;
//     one Done pulse.
//  2. Rst, then Start with Desc=1 -> final contents {63,57,57,56,55,54,53,53,52,51,50,49,48,47,46,39};
//     SwapCount=72.
//  3. Sort an already-ascending file with Desc=0 -> no W_en cycles; SwapCount=0;
//     Done high exactly in cycle 46 after E0.
//  4. Write all 16 entries to 8'd7, then Start -> no writes; SwapCount=0; single pass;
//     values unchanged.
//  5. Pulse Start again at cycles 5 and 20 during a sort -> the result and SwapCount match
//     scenario 1; exactly one Done pulse.
//  6. Assert Rst during the 3rd WR_A -> next cycle Busy=0, W_en=0, SwapCount=0;
//     the register file holds its reset contents; a new Start then behaves as in scenario 1.

Source files
------------

// File: rtl/regfile_bubble_sorter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_bubble_sorter
//
// Purpose:
//   In-place bubble sort of a DEPTH-entry register file. The sorter works
//   through the file's single combinational read port and single synchronous
//   write port. Each pass is one entry shorter than the previous one. The
//   sort stops early after any pass that performs no swaps.
//
// Ports:
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset
//   Start      sort request, sampled only while idle
//   Desc       order select (0 ascending, 1 descending), latched with Start
//   R_Data     register-file read data (combinational w.r.t. R_Addr)
//   R_Addr     register-file read address
//   R_en       register-file read enable
//   W_Addr     register-file write address
//   W_en       register-file write enable
//   W_Data     register-file write data
//   Busy       high whenever a sort is in progress (including DONE)
//   Done       one-cycle completion pulse
//   SwapCount  swaps performed by the last/current sort, saturating
// ---------------------------------------------------------------------------
module regfile_bubble_sorter #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Desc,
    input  logic [WIDTH-1:0]   R_Data,
    output logic [ADDR_W-1:0]  R_Addr,
    output logic               R_en,
    output logic [ADDR_W-1:0]  W_Addr,
    output logic               W_en,
    output logic [WIDTH-1:0]   W_Data,
    output logic               Busy,
    output logic               Done,
    output logic [COUNT_W-1:0] SwapCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]    limit_q, limit_d;
    logic                 swapped_q, swapped_d;
    logic                 desc_q, desc_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;

    logic [ADDR_W-1:0]    idx_nxt;
    logic                 out_of_order;
    logic                 end_cmp;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    assign idx_nxt      = idx_q + ADDR_W'(1);
    // Strict compares: equal entries stay where they are.
    assign out_of_order = desc_q ? (a_q < b_q) : (a_q > b_q);

    // Outputs decode purely from registered state, so a reset edge forces
    // every output to its idle value in the following cycle.
    always_comb begin
        R_en   = 1'b0;
        W_en   = 1'b0;
        R_Addr = '0;
        W_Addr = '0;
        W_Data = '0;
        case (state_q)
            S_RD_A: begin
                R_en   = 1'b1;
                R_Addr = idx_q;
            end
            S_RD_B: begin
                R_en   = 1'b1;
                R_Addr = idx_nxt;
            end
            S_WR_A: begin
                W_en   = 1'b1;
                W_Addr = idx_q;
                W_Data = b_q;
            end
            S_WR_B: begin
                W_en   = 1'b1;
                W_Addr = idx_nxt;
                W_Data = a_q;
            end
            default: ;
        endcase
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign SwapCount = cnt_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        limit_d   = limit_q;
        swapped_d = swapped_q;
        desc_d    = desc_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        end_cmp   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    desc_d    = Desc;
                    idx_d     = '0;
                    limit_d   = ADDR_W'(DEPTH - 2);
                    swapped_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RD_A;
                end
            end
            S_RD_A: begin
                a_d     = R_Data;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                b_d     = R_Data;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (out_of_order) begin
                    state_d = S_WR_A;
                end else begin
                    end_cmp = 1'b1;
                end
            end
            S_WR_A: begin
                state_d = S_WR_B;
            end
            S_WR_B: begin
                swapped_d = 1'b1;
                cnt_d     = sat_inc(cnt_q);
                end_cmp   = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Advance to the next pair, start a shorter pass, or finish.
        // swapped_d already includes a swap made in this very cycle.
        if (end_cmp) begin
            if (idx_q < limit_q) begin
                idx_d   = idx_nxt;
                state_d = S_RD_A;
            end else if (!swapped_d || (limit_q == '0)) begin
                state_d = S_DONE;
            end else begin
                limit_d   = limit_q - ADDR_W'(1);
                idx_d     = '0;
                swapped_d = 1'b0;
                state_d   = S_RD_A;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            limit_q   <= '0;
            swapped_q <= 1'b0;
            desc_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            swapped_q <= swapped_d;
            desc_q    <= desc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Operand holding registers carry data only; no reset needed.
    always_ff @(posedge Clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

endmodule

// File: tb/tb_regfile_bubble_sorter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_regfile_bubble_sorter
//
// Purpose:
//   Directed bench for regfile_bubble_sorter. Contains a 16x8 register-file
//   model (combinational read, synchronous write, reset to the power-on
//   contents) wired to the sorter, and checks results against hand-computed
//   vectors.
// ---------------------------------------------------------------------------
module tb_regfile_bubble_sorter;

    localparam int DEPTH   = 16;
    localparam int WIDTH   = 8;
    localparam int ADDR_W  = 4;
    localparam int COUNT_W = 8;
    localparam int LIMIT   = 2000;

    typedef logic [WIDTH-1:0] vec_t [DEPTH];

    localparam vec_t INIT_V = '{8'd47, 8'd56, 8'd51, 8'd48, 8'd53, 8'd55, 8'd52, 8'd39,
                                8'd54, 8'd49, 8'd57, 8'd50, 8'd46, 8'd53, 8'd63, 8'd57};
    localparam vec_t ASC_V  = '{8'd39, 8'd46, 8'd47, 8'd48, 8'd49, 8'd50, 8'd51, 8'd52,
                                8'd53, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57, 8'd57, 8'd63};
    localparam vec_t DSC_V  = '{8'd63, 8'd57, 8'd57, 8'd56, 8'd55, 8'd54, 8'd53, 8'd53,
                                8'd52, 8'd51, 8'd50, 8'd49, 8'd48, 8'd47, 8'd46, 8'd39};

    logic               Clk = 1'b0;
    logic               Rst;
    logic               Start;
    logic               Desc;
    logic [WIDTH-1:0]   R_Data;
    logic [ADDR_W-1:0]  R_Addr;
    logic               R_en;
    logic [ADDR_W-1:0]  W_Addr;
    logic               W_en;
    logic [WIDTH-1:0]   W_Data;
    logic               Busy;
    logic               Done;
    logic [COUNT_W-1:0] SwapCount;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               ld_en;
    logic [WIDTH-1:0]   ld_val;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    regfile_bubble_sorter #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .COUNT_W(COUNT_W)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Desc     (Desc),
        .R_Data   (R_Data),
        .R_Addr   (R_Addr),
        .R_en     (R_en),
        .W_Addr   (W_Addr),
        .W_en     (W_en),
        .W_Data   (W_Data),
        .Busy     (Busy),
        .Done     (Done),
        .SwapCount(SwapCount)
    );

    // Register-file model: reset wins over a bulk fill, which wins over a write.
    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_V[i];
        end else if (ld_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ld_val;
        end else if (W_en) begin
            mem[W_Addr] <= W_Data;
        end
    end

    assign R_Data = mem[R_Addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input vec_t exp);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(mem[i]), 32'(exp[i]));
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Starts a sort and steps it cycle by cycle (cycle 1 = first cycle after
    // the Start edge). Optionally re-pulses Start at cycles s1/s2, or asserts
    // Rst during the cycle of the abort_wen-th write.
    task automatic run_sort(input logic desc, input int s1, input int s2, input int abort_wen,
                            output int wen_cnt, output int done_cnt, output int done_cyc,
                            output logic tout);
        int cyc;
        wen_cnt  = 0;
        done_cnt = 0;
        done_cyc = 0;
        tout     = 1'b0;
        Start    = 1'b1;
        Desc     = desc;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        Desc  = ~desc;
        cyc   = 1;
        while (1) begin
            if (W_en) wen_cnt++;
            if (Done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (abort_wen != 0 && wen_cnt == abort_wen) begin
                Rst = 1'b1;
                @(posedge Clk);
                @(negedge Clk);
                Rst = 1'b0;
                break;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 3) break;
            if (cyc >= LIMIT) begin
                tout = 1'b1;
                break;
            end
            Start = (cyc == s1) || (cyc == s2);
            @(posedge Clk);
            @(negedge Clk);
            cyc++;
        end
        Start = 1'b0;
        Desc  = 1'b0;
    endtask

    initial begin
        int   wen, dn, dcyc;
        logic tout;

        Rst    = 1'b1;
        Start  = 1'b0;
        Desc   = 1'b0;
        ld_en  = 1'b0;
        ld_val = '0;

        // Reset state
        do_reset();
        chk("rst_busy",   32'(Busy),      0);
        chk("rst_done",   32'(Done),      0);
        chk("rst_ren",    32'(R_en),      0);
        chk("rst_wen",    32'(W_en),      0);
        chk("rst_raddr",  32'(R_Addr),    0);
        chk("rst_waddr",  32'(W_Addr),    0);
        chk("rst_wdata",  32'(W_Data),    0);
        chk("rst_swaps",  32'(SwapCount), 0);

        // 1: ascending sort of reset contents
        run_sort(1'b0, 0, 0, 0, wen, dn, dcyc, tout);
        chk("s1_timeout", 32'(tout), 0);
        chk_mem("s1_mem", ASC_V);
        chk("s1_swaps",   32'(SwapCount), 46);
        chk("s1_wen",     32'(wen), 92);
        chk("s1_done",    32'(dn), 1);
        chk("s1_idle",    32'(Busy), 0);

        // 3: already ascending -> single pass, no writes
        run_sort(1'b0, 0, 0, 0, wen, dn, dcyc, tout);
        chk("s3_timeout", 32'(tout), 0);
        chk("s3_wen",     32'(wen), 0);
        chk("s3_swaps",   32'(SwapCount), 0);
        chk("s3_donecyc", 32'(dcyc), 46);
        chk("s3_done",    32'(dn), 1);
        chk_mem("s3_mem", ASC_V);

        // 2: descending sort of reset contents
        do_reset();
        run_sort(1'b1, 0, 0, 0, wen, dn, dcyc, tout);
        chk("s2_timeout", 32'(tout), 0);
        chk_mem("s2_mem", DSC_V);
        chk("s2_swaps",   32'(SwapCount), 72);
        chk("s2_wen",     32'(wen), 144);
        chk("s2_done",    32'(dn), 1);

        // 4: all entries equal
        ld_en  = 1'b1;
        ld_val = 8'd7;
        @(posedge Clk);
        @(negedge Clk);
        ld_en  = 1'b0;
        run_sort(1'b0, 0, 0, 0, wen, dn, dcyc, tout);
        chk("s4_timeout", 32'(tout), 0);
        chk("s4_wen",     32'(wen), 0);
        chk("s4_swaps",   32'(SwapCount), 0);
        chk("s4_donecyc", 32'(dcyc), 46);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("s4_mem[%0d]", i), 32'(mem[i]), 7);

        // 5: Start pulses while busy are ignored
        do_reset();
        run_sort(1'b0, 5, 20, 0, wen, dn, dcyc, tout);
        chk("s5_timeout", 32'(tout), 0);
        chk_mem("s5_mem", ASC_V);
        chk("s5_swaps",   32'(SwapCount), 46);
        chk("s5_done",    32'(dn), 1);
        chk("s5_idle",    32'(Busy), 0);

        // 6: reset during the third WR_A (fifth write cycle)
        do_reset();
        run_sort(1'b0, 0, 0, 5, wen, dn, dcyc, tout);
        chk("s6_timeout", 32'(tout), 0);
        chk("s6_busy",    32'(Busy), 0);
        chk("s6_wen",     32'(W_en), 0);
        chk("s6_swaps",   32'(SwapCount), 0);
        chk_mem("s6_mem", INIT_V);
        run_sort(1'b0, 0, 0, 0, wen, dn, dcyc, tout);
        chk("s6b_timeout", 32'(tout), 0);
        chk_mem("s6b_mem", ASC_V);
        chk("s6b_swaps",  32'(SwapCount), 46);
        chk("s6b_done",   32'(dn), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
